// File: rtl/range_counter_if.sv
// Control, configuration and status bundle for range_counter.
// The slave side is the counter; the master side supplies the controls and observes the status.
interface range_counter_if #(
    parameter int unsigned P_WIDTH      = 8,
    parameter int unsigned P_STEP_WIDTH = 4
) ();
    logic                    en;
    logic                    clr;
    logic                    load;
    logic [P_WIDTH-1:0]      load_value;
    logic [P_WIDTH-1:0]      param_lower;
    logic [P_WIDTH-1:0]      param_upper;
    logic [P_STEP_WIDTH-1:0] param_step;
    logic                    param_direction;
    logic                    param_cycle_en;
    logic [P_WIDTH-1:0]      counter;
    logic                    at_upper;
    logic                    at_lower;
    logic                    wrap_pulse;
    logic                    sat_pulse;
    logic                    range_err;
    logic                    cfg_err;

    modport master (
        output en, clr, load, load_value, param_lower, param_upper,
               param_step, param_direction, param_cycle_en,
        input  counter, at_upper, at_lower, wrap_pulse, sat_pulse, range_err, cfg_err
    );

    modport slave (
        input  en, clr, load, load_value, param_lower, param_upper,
               param_step, param_direction, param_cycle_en,
        output counter, at_upper, at_lower, wrap_pulse, sat_pulse, range_err, cfg_err
    );
endinterface

// File: rtl/range_counter.sv
// Up/down counter with run-time bounds, step, parallel load, and wrap/saturate behaviour.
// The count and the wrap/sat/range-error pulses are registered; the bound flags are combinational.
module range_counter #(
    parameter int unsigned P_WIDTH      = 8,
    parameter int unsigned P_STEP_WIDTH = 4
) (
    input  logic            aclk,
    input  logic            reset,
    range_counter_if.slave  bus
);
    localparam int unsigned LP_EXT_W = P_WIDTH + 1;

    logic [P_WIDTH-1:0]      r_counter;
    logic                    r_wrap_pulse;
    logic                    r_sat_pulse;
    logic                    r_range_err;

    logic [P_WIDTH-1:0]      w_cnt_next;
    logic                    w_wrap_next;
    logic                    w_sat_next;
    logic                    w_err_next;
    logic                    w_cfg_err;
    logic [P_STEP_WIDTH-1:0] w_step;
    logic [LP_EXT_W-1:0]     w_cnt_ext;
    logic [LP_EXT_W-1:0]     w_step_ext;
    logic [LP_EXT_W-1:0]     w_lower_ext;
    logic [LP_EXT_W-1:0]     w_upper_ext;
    logic [LP_EXT_W-1:0]     w_sum;
    logic [LP_EXT_W-1:0]     w_diff;
    logic                    w_sum_over;
    logic                    w_diff_under;
    logic [P_WIDTH-1:0]      w_load_clamped;

    assign w_cfg_err   = bus.param_lower > bus.param_upper;
    assign w_step      = bus.param_step;
    assign w_cnt_ext   = LP_EXT_W'(r_counter);
    assign w_step_ext  = LP_EXT_W'(w_step);
    assign w_lower_ext = LP_EXT_W'(bus.param_lower);
    assign w_upper_ext = LP_EXT_W'(bus.param_upper);

    // One extra bit keeps the sum free of native overflow and gives the difference a sign bit.
    assign w_sum        = w_cnt_ext + w_step_ext;
    assign w_diff       = w_cnt_ext - w_step_ext;
    assign w_sum_over   = w_sum > w_upper_ext;
    assign w_diff_under = w_diff[P_WIDTH] || (w_diff < w_lower_ext);

    always_comb begin
        if (bus.load_value < bus.param_lower) begin
            w_load_clamped = bus.param_lower;
        end else if (bus.load_value > bus.param_upper) begin
            w_load_clamped = bus.param_upper;
        end else begin
            w_load_clamped = bus.load_value;
        end
    end

    // Next-state selection: load > clr > out-of-range fix-up > count.
    always_comb begin
        w_cnt_next  = r_counter;
        w_wrap_next = 1'b0;
        w_sat_next  = 1'b0;
        w_err_next  = 1'b0;
        if (bus.en && !w_cfg_err) begin
            if (bus.load) begin
                w_cnt_next = w_load_clamped;
                w_err_next = w_load_clamped != bus.load_value;
            end else if (bus.clr) begin
                w_cnt_next = bus.param_direction ? bus.param_lower : bus.param_upper;
            end else if (r_counter > bus.param_upper) begin
                w_cnt_next = bus.param_upper;
                w_err_next = 1'b1;
            end else if (r_counter < bus.param_lower) begin
                w_cnt_next = bus.param_lower;
                w_err_next = 1'b1;
            end else if (w_step != '0) begin
                if (bus.param_direction) begin
                    if (!w_sum_over) begin
                        w_cnt_next = w_sum[P_WIDTH-1:0];
                    end else if (bus.param_cycle_en) begin
                        w_cnt_next  = bus.param_lower;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_cnt_next = bus.param_upper;
                        w_sat_next = 1'b1;
                    end
                end else begin
                    if (!w_diff_under) begin
                        w_cnt_next = w_diff[P_WIDTH-1:0];
                    end else if (bus.param_cycle_en) begin
                        w_cnt_next  = bus.param_upper;
                        w_wrap_next = 1'b1;
                    end else begin
                        w_cnt_next = bus.param_lower;
                        w_sat_next = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_counter    <= '0;
            r_wrap_pulse <= 1'b0;
            r_sat_pulse  <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_counter    <= w_cnt_next;
            r_wrap_pulse <= w_wrap_next;
            r_sat_pulse  <= w_sat_next;
            r_range_err  <= w_err_next;
        end
    end

    assign bus.counter    = r_counter;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.sat_pulse  = r_sat_pulse;
    assign bus.range_err  = r_range_err;
    assign bus.at_upper   = r_counter == bus.param_upper;
    assign bus.at_lower   = r_counter == bus.param_lower;
    assign bus.cfg_err    = w_cfg_err;
endmodule

// File: tb/tb_range_counter.sv
// Self-checking bench for range_counter: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_range_counter;
    logic aclk = 1'b0;
    logic rst  = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    int m_cnt  = 0;
    bit m_wrap = 1'b0;
    bit m_sat  = 1'b0;
    bit m_err  = 1'b0;

    range_counter_if #(.P_WIDTH(8), .P_STEP_WIDTH(4)) bus ();

    range_counter #(.P_WIDTH(8), .P_STEP_WIDTH(4)) dut (
        .aclk  (aclk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 aclk = ~aclk;

    // Reference: evaluates the rules on the inputs presented before the coming edge.
    task automatic model_edge();
        int lo, hi, st, v;
        lo = int'(bus.param_lower);
        hi = int'(bus.param_upper);
        st = int'(bus.param_step);
        m_wrap = 1'b0;
        m_sat  = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_cnt = 0;
        end else if (bus.en && lo <= hi) begin
            if (bus.load) begin
                v = int'(bus.load_value);
                if (v < lo) v = lo;
                if (v > hi) v = hi;
                m_err = (v != int'(bus.load_value));
                m_cnt = v;
            end else if (bus.clr) begin
                m_cnt = bus.param_direction ? lo : hi;
            end else if (m_cnt > hi || m_cnt < lo) begin
                m_cnt = (m_cnt > hi) ? hi : lo;
                m_err = 1'b1;
            end else if (st != 0) begin
                v = bus.param_direction ? m_cnt + st : m_cnt - st;
                if (v > hi || v < lo) begin
                    if (bus.param_cycle_en) begin
                        m_cnt  = bus.param_direction ? lo : hi;
                        m_wrap = 1'b1;
                    end else begin
                        m_cnt = bus.param_direction ? hi : lo;
                        m_sat = 1'b1;
                    end
                end else begin
                    m_cnt = v;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [13:0] exp_vec();
        int lo, hi;
        lo = int'(bus.param_lower);
        hi = int'(bus.param_upper);
        return {8'(m_cnt), m_wrap, m_sat, m_err, m_cnt == hi, m_cnt == lo, lo > hi};
    endfunction

    function automatic logic [13:0] act_vec();
        return {bus.counter, bus.wrap_pulse, bus.sat_pulse, bus.range_err,
                bus.at_upper, bus.at_lower, bus.cfg_err};
    endfunction

    task automatic set_cfg(int lo, int hi, int st, bit dir, bit cyc);
        bus.param_lower     = 8'(lo);
        bus.param_upper     = 8'(hi);
        bus.param_step      = 4'(st);
        bus.param_direction = dir;
        bus.param_cycle_en  = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b1; bus.load = 1'b1; bus.load_value = 8'd77;
        tick();
        tick();
        n_cmp++;
        if (act_vec() !== exp_vec() || bus.counter !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h exp %h", act_vec(), exp_vec());
        end
        rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0;
    endtask

    task automatic test_wrap_full();
        int wraps = 0;
        bit up_seen = 1'b0;
        set_cfg(0, 255, 1, 1'b1, 1'b1);
        bus.en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (bus.wrap_pulse) wraps++;
            if (bus.counter == 8'd255 && bus.at_upper) up_seen = 1'b1;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_full_cycle%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (wraps != 1 || !up_seen || bus.counter !== 8'd0) begin
            n_bad++;
            $display("FAIL wrap_full_summary: got wraps=%0d at_upper_seen=%0b cnt=%0d exp 1 1 0",
                     wraps, up_seen, bus.counter);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_sat_up();
        int exp_c[5] = '{13, 16, 19, 20, 20};
        bit exp_s[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        set_cfg(10, 20, 3, 1'b1, 1'b0);
        bus.en = 1'b1; bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n_cmp++;
        if (bus.counter !== 8'd10) begin
            n_bad++;
            $display("FAIL sat_up_clr: got %0d exp 10", bus.counter);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.counter !== 8'(exp_c[i]) || bus.sat_pulse !== exp_s[i] || act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL sat_up_step%0d: got cnt=%0d sat=%0b exp cnt=%0d sat=%0b",
                         i, bus.counter, bus.sat_pulse, exp_c[i], exp_s[i]);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_down_wrap();
        int exp_c[4] = '{20, 16, 12, 20};
        bit exp_w[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_cfg(10, 20, 4, 1'b0, 1'b1);
        bus.en = 1'b1; bus.load = 1'b1; bus.load_value = 8'd12;
        tick();
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.counter !== 8'(exp_c[i]) || bus.wrap_pulse !== exp_w[i] || act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL down_wrap_step%0d: got cnt=%0d wrap=%0b exp cnt=%0d wrap=%0b",
                         i, bus.counter, bus.wrap_pulse, exp_c[i], exp_w[i]);
            end
        end
        bus.en = 1'b0;
    endtask

    task automatic test_load();
        set_cfg(10, 20, 1, 1'b1, 1'b1);
        bus.en = 1'b1; bus.load = 1'b1; bus.load_value = 8'd5;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd10 || bus.range_err !== 1'b1) begin
            n_bad++;
            $display("FAIL load_clamp: got cnt=%0d err=%0b exp cnt=10 err=1", bus.counter, bus.range_err);
        end
        bus.clr = 1'b1; bus.load_value = 8'd15;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd15 || {bus.wrap_pulse, bus.sat_pulse, bus.range_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL load_over_clr: got cnt=%0d pulses=%b exp cnt=15 pulses=000", bus.counter,
                     {bus.wrap_pulse, bus.sat_pulse, bus.range_err});
        end
        bus.clr = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    endtask

    task automatic test_fixup_cfg();
        set_cfg(10, 20, 1, 1'b1, 1'b1);
        bus.en = 1'b1; bus.load = 1'b1; bus.load_value = 8'd18;
        tick();
        bus.load = 1'b0;
        bus.param_upper = 8'd15;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd15 || bus.range_err !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL fixup_upper: got cnt=%0d err=%0b exp cnt=15 err=1", bus.counter, bus.range_err);
        end
        bus.param_lower = 8'd16;
        #1;
        n_cmp++;
        if (bus.cfg_err !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_err_flag: got %0b exp 1", bus.cfg_err);
        end
        bus.load = 1'b1; bus.load_value = 8'd3; bus.clr = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.counter !== 8'd15 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL cfg_err_freeze: got %h exp %h", act_vec(), exp_vec());
        end
        bus.load = 1'b0; bus.clr = 1'b0; bus.en = 1'b0;
    endtask

    task automatic test_pinned();
        set_cfg(7, 7, 2, 1'b1, 1'b0);
        bus.en = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bus.counter !== 8'd7 || bus.sat_pulse !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL pinned_sat: got cnt=%0d sat=%0b exp cnt=7 sat=1", bus.counter, bus.sat_pulse);
        end
        bus.param_cycle_en = 1'b1; bus.param_direction = 1'b0;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd7 || bus.wrap_pulse !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL pinned_wrap: got cnt=%0d wrap=%0b exp cnt=7 wrap=1", bus.counter, bus.wrap_pulse);
        end
        bus.param_step = 4'd0;
        tick();
        n_cmp++;
        if ({bus.wrap_pulse, bus.sat_pulse, bus.range_err} !== 3'b000 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL step_zero: got %h exp %h", act_vec(), exp_vec());
        end
        bus.en = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_cfg(3, 200, 5, 1'b1, 1'b1);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; bus.load = 1'b1; bus.load_value = 8'd100;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd0 || {bus.wrap_pulse, bus.sat_pulse, bus.range_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_mid: got cnt=%0d pulses=%b exp cnt=0 pulses=000", bus.counter,
                     {bus.wrap_pulse, bus.sat_pulse, bus.range_err});
        end
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd0 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL hold_disabled: got %h exp %h", act_vec(), exp_vec());
        end
        bus.en = 1'b1;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd3 || bus.range_err !== 1'b1 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL post_reset_fixup: got cnt=%0d err=%0b exp cnt=3 err=1", bus.counter, bus.range_err);
        end
        tick();
        bus.en = 1'b0;
        tick();
        n_cmp++;
        if (bus.counter !== 8'd8 || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL en_low_hold: got cnt=%0d exp 8", bus.counter);
        end
    endtask

    task automatic test_random();
        int lo, hi;
        for (int i = 0; i < 3000; i++) begin
            if (i % 25 == 0) begin
                lo = int'($urandom_range(0, 200));
                hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                                  : lo + int'($urandom_range(0, 55));
                set_cfg(lo, hi, int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 7) == 0) bus.param_step = 4'($urandom);
            if ($urandom_range(0, 15) == 0) bus.param_direction = ~bus.param_direction;
            if ($urandom_range(0, 15) == 0) bus.param_cycle_en = ~bus.param_cycle_en;
            rst             = ($urandom_range(0, 99) == 0);
            bus.en          = ($urandom_range(0, 9) != 0);
            bus.load        = ($urandom_range(0, 19) == 0);
            bus.clr         = ($urandom_range(0, 19) == 0);
            bus.load_value  = 8'($urandom);
            tick();
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.clr = 1'b0;
    endtask

    initial begin
        bus.en = 1'b0; bus.clr = 1'b0; bus.load = 1'b0; bus.load_value = 8'd0;
        set_cfg(0, 255, 1, 1'b1, 1'b1);
        test_reset();
        test_wrap_full();
        test_sat_up();
        test_down_wrap();
        test_load();
        test_fixup_cfg();
        test_pinned();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
